// File: rtl/ahb_mtx_in_stage_if.sv
// ahb_mtx_in_stage_if: master-side AHB port plus output-stage feedback for one matrix input stage
interface ahb_mtx_in_stage_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  HSELS;
    logic [ADDR_WIDTH-1:0] HADDRS;
    logic [1:0]            HTRANSS;
    logic                  HWRITES;
    logic [2:0]            HSIZES;
    logic [2:0]            HBURSTS;
    logic [3:0]            HPROTS;
    logic                  HMASTLOCKS;
    logic                  HREADYS;
    logic                  active_trans;
    logic                  readyout_m;
    logic                  resp_m;
    logic                  dec_miss;
    logic                  req_port;
    logic [ADDR_WIDTH-1:0] HADDRM;
    logic [1:0]            HTRANSM;
    logic                  HWRITEM;
    logic [2:0]            HSIZEM;
    logic [2:0]            HBURSTM;
    logic [3:0]            HPROTM;
    logic                  HMASTLOCKM;
    logic                  held_tran;
    logic                  HREADYOUTS;
    logic                  HRESPS;

    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
        input  active_trans, readyout_m, resp_m, dec_miss,
        output req_port, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTLOCKM,
        output held_tran, HREADYOUTS, HRESPS
    );

    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
        output active_trans, readyout_m, resp_m, dec_miss,
        input  req_port, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTLOCKM,
        input  held_tran, HREADYOUTS, HRESPS
    );
endinterface

// File: rtl/ahb_mtx_in_stage.sv
// ahb_mtx_in_stage: AHB matrix input stage, live/held address forwarding; AHB_MTX_INSTG_DEFSLV_EN adds a built-in default slave
module ahb_mtx_in_stage #(
    parameter int ADDR_WIDTH = 32
) (
    input logic              HCLK,
    input logic              HRESETn,
    ahb_mtx_in_stage_if.slave bus
);
`ifdef AHB_MTX_INSTG_DEFSLV_EN
    typedef enum logic [2:0] {ST_IDLE, ST_HOLD, ST_DATA, ST_ERR1, ST_ERR2} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_HOLD, ST_DATA} state_t;
`endif
    state_t                state_q, state_d;
    logic                  new_tran, miss, fwd, accept, load;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q, lock_q;
    logic [2:0]            size_q, burst_q;
    logic [3:0]            prot_q;

    assign new_tran = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;
`ifdef AHB_MTX_INSTG_DEFSLV_EN
    assign miss = new_tran & bus.dec_miss;
`else
    logic unused_dec_miss;
    assign unused_dec_miss = bus.dec_miss;
    assign miss = 1'b0;
`endif
    assign fwd = new_tran & ~miss;

    // next state, request, forwarded controls and master response
    always_comb begin
        state_d         = state_q;
        accept          = 1'b0;
        load            = 1'b0;
        bus.req_port    = fwd;
        bus.held_tran   = 1'b0;
        bus.HADDRM      = bus.HADDRS;
        bus.HTRANSM     = bus.HTRANSS;
        bus.HWRITEM     = bus.HWRITES;
        bus.HSIZEM      = bus.HSIZES;
        bus.HBURSTM     = bus.HBURSTS;
        bus.HPROTM      = bus.HPROTS;
        bus.HMASTLOCKM  = bus.HMASTLOCKS;
        bus.HREADYOUTS  = 1'b1;
        bus.HRESPS      = 1'b0;
        case (state_q)
            ST_IDLE: accept = 1'b1;
            ST_HOLD: begin
                bus.req_port   = 1'b1;
                bus.held_tran  = 1'b1;
                bus.HADDRM     = addr_q;
                bus.HTRANSM    = 2'b10;
                bus.HWRITEM    = write_q;
                bus.HSIZEM     = size_q;
                bus.HBURSTM    = burst_q;
                bus.HPROTM     = prot_q;
                bus.HMASTLOCKM = lock_q;
                bus.HREADYOUTS = 1'b0;
                state_d        = bus.active_trans ? ST_DATA : ST_HOLD;
            end
            ST_DATA: begin
                bus.HREADYOUTS = bus.readyout_m;
                bus.HRESPS     = bus.resp_m;
                accept         = bus.readyout_m;
            end
`ifdef AHB_MTX_INSTG_DEFSLV_EN
            ST_ERR1: begin
                bus.HREADYOUTS = 1'b0;
                bus.HRESPS     = 1'b1;
                state_d        = ST_ERR2;
            end
            ST_ERR2: begin
                bus.HRESPS = 1'b1;
                accept     = 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            state_d = fwd ? (bus.active_trans ? ST_DATA : ST_HOLD) : ST_IDLE;
            load    = fwd & ~bus.active_trans;
        end
`ifdef AHB_MTX_INSTG_DEFSLV_EN
        if (accept && miss) state_d = ST_ERR1;
`endif
    end

    // state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // holding register, loaded only when a transfer misses its grant
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'b0;
            burst_q <= 3'b0;
            prot_q  <= 4'b0;
            lock_q  <= 1'b0;
        end else if (load) begin
            addr_q  <= bus.HADDRS;
            write_q <= bus.HWRITES;
            size_q  <= bus.HSIZES;
            burst_q <= bus.HBURSTS;
            prot_q  <= bus.HPROTS;
            lock_q  <= bus.HMASTLOCKS;
        end
    end
endmodule

// File: doc/ahb_mtx_in_stage.md
Name: ahb_mtx_in_stage

Overview:
- Slave-side input stage of the AHB matrix; one instance per master-facing port.
- Accepts a master's address phase and forwards it to the output-stage arbiters, either live or from a holding register.
- Generates that port's request into the fixed-priority arbiters.
- Returns HREADYOUT/HRESP to the master, inserting wait states while a transfer is held and not yet granted.

Parameters:
ADDR_WIDTH, 32, width of HADDRS/HADDRM

Ports:
HCLK  input  1  AHB system clock
HRESETn  input  1  AHB system reset, asynchronous, active-low
HSELS  input  1  port select from master side
HADDRS  input  ADDR_WIDTH  address
HTRANSS  input  2  transfer type
HWRITES  input  1  write
HSIZES  input  3  size
HBURSTS  input  3  burst type
HPROTS  input  4  protection
HMASTLOCKS  input  1  locked transfer
HREADYS  input  1  bus-level HREADY seen by master
active_trans  input  1  an output stage accepts this port's address phase this cycle (granted and HREADYM=1)
readyout_m  input  1  HREADY from selected output stage (data phase)
resp_m  input  1  HRESP from selected output stage
dec_miss  input  1  decoded address maps to no slave (used only with macro)
req_port  output  1  request to arbiters
HADDRM  output  ADDR_WIDTH  forwarded address
HTRANSM  output  2  forwarded transfer type
HWRITEM  output  1  forwarded write
HSIZEM  output  3  forwarded size
HBURSTM  output  3  forwarded burst
HPROTM  output  4  forwarded protection
HMASTLOCKM  output  1  forwarded lock
held_tran  output  1  forwarded controls come from holding register
HREADYOUTS  output  1  ready to master
HRESPS  output  1  response to master (0=OKAY, 1=ERROR)

Behaviour:
- Clock and reset: one clock HCLK; asynchronous active-low reset HRESETn.
- new_tran = HSELS & HTRANSS[1] & HREADYS. IDLE/BUSY transfers are never forwarded; they get a zero-wait OKAY.
- States: ST_IDLE, ST_HOLD, ST_DATA (plus ST_ERR1, ST_ERR2 with macro).
- Reset: state=ST_IDLE, holding registers all 0, held_tran=0, req_port=0, HREADYOUTS=1, HRESPS=0.
- req_port = new_tran | (state==ST_HOLD). Combinational, so zero-cycle request latency.
- Forwarded controls:
  - state==ST_HOLD: driven from holding registers, held_tran=1.
  - otherwise: live HxxxS inputs, held_tran=0.
- Held HTRANS is forced to NONSEQ (2'b10), because a SEQ resumed after a lost grant is illegal at the slave.
- ST_IDLE: HREADYOUTS=1, HRESPS=0.
  - new_tran & active_trans -> ST_DATA.
  - new_tran & ~active_trans -> capture all controls, go to ST_HOLD.
  - otherwise stay.
- ST_HOLD: HREADYOUTS=0, HRESPS=0. Holding registers frozen.
  - active_trans -> ST_DATA.
  - otherwise stay indefinitely.
- ST_DATA: HREADYOUTS=readyout_m, HRESPS=resp_m.
  - readyout_m=0: stay. No capture is possible because HREADYS=0.
  - readyout_m=1: evaluate new_tran/active_trans exactly as in ST_IDLE; with no new transfer, go to ST_IDLE.
- Back-to-back: one transfer per cycle sustained when active_trans=1 every cycle.
- Holding register loads only on the IDLE/DATA->HOLD transition. It is never overwritten while in ST_HOLD.
- A two-cycle ERROR seen from the output stage (resp_m=1 with readyout_m 0 then 1) passes straight through.
- A new_tran on the second ERROR cycle is still handled normally.
- Asynchronous reset mid-HOLD or mid-DATA discards the held transfer and returns to reset values immediately.

Optional Feature:
- Macro: AHB_MTX_INSTG_DEFSLV_EN (built-in default slave).
- With macro:
  - new_tran & dec_miss is never requested (req_port=0 for it) and moves to ST_ERR1.
  - ST_ERR1: HREADYOUTS=0, HRESPS=1 -> ST_ERR2.
  - ST_ERR2: HREADYOUTS=1, HRESPS=1, then evaluates new_tran like ST_IDLE.
- Without macro: dec_miss is ignored, no ERR states exist, and every transfer is forwarded.

Test Plan:
- Reset release, HSELS=0 -> req_port=0, HREADYOUTS=1, HRESPS=0, held_tran=0.
- NONSEQ write to 0x2000_0040 with active_trans=1 same cycle, readyout_m=1 next cycle -> no hold, HREADYOUTS=1 both cycles, HADDRM=0x2000_0040 live.
- NONSEQ read 0x0000_1000, active_trans=0 for 3 cycles then 1 -> held_tran=1 for 3 cycles with HADDRM=0x0000_1000, HREADYOUTS=0 for those cycles, then ST_DATA.
- SEQ beat 0x0000_1004 held -> HTRANSM=2'b10 while held_tran=1.
- Slave inserts 2 waits then ERROR (resp_m=1, readyout_m 0,1) -> HREADYOUTS 0,0,0,1; HRESPS=1 on the last two cycles.
- With AHB_MTX_INSTG_DEFSLV_EN, new_tran with dec_miss=1 -> req_port=0; next two cycles HREADYOUTS/HRESPS = 0/1 then 1/1; then back to ST_IDLE.
